cam_req_ctrl: RTL and testbench

//  Initiator-side controller for the cam block: turns a valid/ready request stream (write or search)

---
 rtl/cam_req_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_cam_req_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_req_ctrl.sv
// cam_req_ctrl: initiator-side sequencer for a single cam instance.
//
// Turns a valid/ready request stream (write or search) into cam write pulses and compare-key
// activity, waits for cam busy to clear with a bounded timeout, captures the search result after
// a fixed latency and presents it as a held valid/ready response. Keeps saturating hit and miss
// counters for completed searches.
//
// Ports
//   clk, rst                                clock (rising edge), async active-high reset
//   req_valid/req_ready                     request handshake
//   req_op/req_data/req_addr                0 = write, 1 = search; data or key; write address
//   rsp_valid/rsp_ready                     search response handshake
//   rsp_match/rsp_addr/rsp_err              found flag, matching address, busy-timeout abort
//   cam_write_enable/cam_din/cam_write_addr write side towards the cam
//   cam_cmp_din                             search key towards the cam
//   cam_busy/cam_match/cam_match_addr       status and result from the cam
//   hit_cnt/miss_cnt                        saturating search statistics
//   wr_timeout                              one-cycle pulse when a write gives up on busy
module cam_req_ctrl #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH   = 2,
    parameter int unsigned SEARCH_LAT   = 1,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_match,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_err,
    output logic                  cam_write_enable,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_cmp_din,
    input  logic                  cam_busy,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic                  wr_timeout
);

    localparam int unsigned LatW  = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;
    localparam int unsigned WaitW = $clog2(BUSY_TIMEOUT);

    localparam logic [LatW-1:0]  LatLast  = LatW'(SEARCH_LAT - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrIssue,
        StWrWait,
        StSrWaitIdle,
        StSrLat,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic                  up_q;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic                  rsp_match_q, rsp_match_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  wr_to_q, wr_to_d;
    logic [CNT_WIDTH-1:0]  hit_q, hit_d;
    logic [CNT_WIDTH-1:0]  miss_q, miss_d;
    logic                  req_fire;
    logic                  rsp_fire;

    // up_q keeps req_ready low until the first clock edge after reset is released.
    assign req_ready        = (state_q == StIdle) & up_q & ~cam_busy;
    assign req_fire         = req_valid & req_ready;
    assign rsp_valid        = (state_q == StResp);
    assign rsp_fire         = rsp_valid & rsp_ready;
    assign cam_write_enable = (state_q == StWrIssue);

    assign cam_din        = din_q;
    assign cam_write_addr = waddr_q;
    assign cam_cmp_din    = key_q;
    assign rsp_match      = rsp_match_q;
    assign rsp_addr       = rsp_addr_q;
    assign rsp_err        = rsp_err_q;
    assign hit_cnt        = hit_q;
    assign miss_cnt       = miss_q;
    assign wr_timeout     = wr_to_q;

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        waddr_d     = waddr_q;
        key_d       = key_q;
        lat_d       = lat_q;
        wait_d      = wait_q;
        rsp_match_d = rsp_match_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        wr_to_d     = 1'b0;
        hit_d       = hit_q;
        miss_d      = miss_q;

        case (state_q)
            StIdle: begin
                if (req_fire) begin
                    wait_d = '0;
                    if (req_op) begin
                        key_d   = req_data;
                        state_d = StSrWaitIdle;
                    end else begin
                        din_d   = req_data;
                        waddr_d = req_addr;
                        state_d = StWrIssue;
                    end
                end
            end

            StWrIssue: begin
                wait_d  = '0;
                state_d = StWrWait;
            end

            StWrWait: begin
                if (!cam_busy) begin
                    state_d = StIdle;
                end else if (wait_q == WaitLast) begin
                    wr_to_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end

            StSrWaitIdle: begin
                if (!cam_busy) begin
                    lat_d   = '0;
                    state_d = StSrLat;
                end else if (wait_q == WaitLast) begin
                    rsp_match_d = 1'b0;
                    rsp_addr_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end

            StSrLat: begin
                // A busy cam invalidates the compare in flight; start the search over.
                if (cam_busy) begin
                    wait_d  = '0;
                    state_d = StSrWaitIdle;
                end else if (lat_q == LatLast) begin
                    rsp_match_d = cam_match;
                    rsp_addr_d  = cam_match ? cam_match_addr : '0;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end

            StResp: begin
                if (rsp_fire) begin
                    if (rsp_match_q) begin
                        if (hit_q != '1) begin
                            hit_d = hit_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        if (miss_q != '1) begin
                            miss_d = miss_q + CNT_WIDTH'(1);
                        end
                    end
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            up_q        <= 1'b0;
            din_q       <= '0;
            waddr_q     <= '0;
            key_q       <= '0;
            lat_q       <= '0;
            wait_q      <= '0;
            rsp_match_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            wr_to_q     <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            up_q        <= 1'b1;
            din_q       <= din_d;
            waddr_q     <= waddr_d;
            key_q       <= key_d;
            lat_q       <= lat_d;
            wait_q      <= wait_d;
            rsp_match_q <= rsp_match_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
            wr_to_q     <= wr_to_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

endmodule

// File: tb/tb_cam_req_ctrl.sv
// Bench for cam_req_ctrl: a small behavioural cam drives busy/match, a reference table of the
// requested writes predicts every search response, directed steps cover the listed scenarios and
// a random write/search phase follows.
module tb_cam_req_ctrl;

    localparam int unsigned BusyTimeout = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [3:0]  req_data = '0;
    logic [1:0]  req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_match;
    logic [1:0]  rsp_addr;
    logic        rsp_err;
    logic        cam_write_enable;
    logic [3:0]  cam_din;
    logic [1:0]  cam_write_addr;
    logic [3:0]  cam_cmp_din;
    logic        cam_busy;
    logic        cam_match = 1'b0;
    logic [1:0]  cam_match_addr = '0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic        wr_timeout;

    cam_req_ctrl #(
        .DATA_WIDTH  (4),
        .ADDR_WIDTH  (2),
        .SEARCH_LAT  (1),
        .BUSY_TIMEOUT(BusyTimeout),
        .CNT_WIDTH   (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_data        (req_data),
        .req_addr        (req_addr),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_match       (rsp_match),
        .rsp_addr        (rsp_addr),
        .rsp_err         (rsp_err),
        .cam_write_enable(cam_write_enable),
        .cam_din         (cam_din),
        .cam_write_addr  (cam_write_addr),
        .cam_cmp_din     (cam_cmp_din),
        .cam_busy        (cam_busy),
        .cam_match       (cam_match),
        .cam_match_addr  (cam_match_addr),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt),
        .wr_timeout      (wr_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural cam ----------------
    logic [3:0] cm_mem [4];
    bit         cm_vld [4];
    bit         busy_m = 1'b0;
    bit         force_busy = 1'b0;
    int         busy_left = 0;
    int         wr_busy_len = 0;
    logic       pend_m = 1'b0;
    logic [1:0] pend_a = '0;

    assign cam_busy = busy_m | force_busy;

    // One cycle compare latency; a miss reports a junk address so the controller must zero it.
    always @(negedge clk) begin : cam_model
        logic       mm;
        logic [1:0] ma;
        cam_match      <= pend_m;
        cam_match_addr <= pend_a;
        mm = 1'b0;
        ma = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if (!mm && cm_vld[i] && cm_mem[i] == cam_cmp_din) begin
                mm = 1'b1;
                ma = 2'(i);
            end
        end
        pend_m <= mm;
        pend_a <= ma;
        if (cam_write_enable === 1'b1) begin
            cm_mem[cam_write_addr] <= cam_din;
            cm_vld[cam_write_addr] <= 1'b1;
            busy_m    <= (wr_busy_len > 0);
            busy_left <= (wr_busy_len > 0) ? wr_busy_len - 1 : 0;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_m <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [3:0] ref_mem [4];
    bit         ref_vld [4];
    int         exp_hit = 0;
    int         exp_miss = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic void ref_lookup(input logic [3:0] key, output bit m, output logic [1:0] a);
        m = 1'b0;
        a = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ref_vld[i] && ref_mem[i] == key) begin
                m = 1'b1;
                a = 2'(i);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, " rsp_match"}, 32'(rsp_match), 0);
        chk({tag, " rsp_addr"}, 32'(rsp_addr), 0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 0);
        chk({tag, " cam_we"}, 32'(cam_write_enable), 0);
        chk({tag, " cam_din"}, 32'(cam_din), 0);
        chk({tag, " cam_waddr"}, 32'(cam_write_addr), 0);
        chk({tag, " cam_cmp_din"}, 32'(cam_cmp_din), 0);
        chk({tag, " hit_cnt"}, 32'(hit_cnt), 0);
        chk({tag, " miss_cnt"}, 32'(miss_cnt), 0);
        chk({tag, " wr_timeout"}, 32'(wr_timeout), 0);
    endtask

    task automatic send(input bit op, input logic [3:0] d, input logic [1:0] a, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_addr  = a;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("req accepted", 32'(ok), 1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #1;
            if (req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d, input int blen);
        bit ok;
        wr_busy_len = blen;
        send(1'b0, d, a, ok);
        if (ok) begin
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
        end
        wait_idle("write completes");
    endtask

    task automatic get_rsp(input string tag, input bit em, input logic [1:0] ea, input bit ee,
                           input int hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " rsp_valid"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, " rsp_match"}, 32'(rsp_match), 32'(em));
            chk({tag, " rsp_addr"}, 32'(rsp_addr), 32'(ea));
            chk({tag, " rsp_err"}, 32'(rsp_err), 32'(ee));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, " held valid"}, 32'(rsp_valid), 1);
                chk({tag, " held match"}, 32'(rsp_match), 32'(em));
                chk({tag, " held addr"}, 32'(rsp_addr), 32'(ea));
                chk({tag, " held req_ready"}, 32'(req_ready), 0);
                chk({tag, " held hit"}, 32'(hit_cnt), 32'(exp_hit));
                chk({tag, " held miss"}, 32'(miss_cnt), 32'(exp_miss));
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            if (em) exp_hit++;
            else exp_miss++;
            @(negedge clk);
            chk({tag, " rsp dropped"}, 32'(rsp_valid), 0);
            chk({tag, " hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
            chk({tag, " miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
        end
    endtask

    task automatic search_chk(input logic [3:0] key, input bit em, input logic [1:0] ea,
                              input int hold);
        bit ok;
        send(1'b1, key, 2'd0, ok);
        if (ok) get_rsp("search", em, ea, 1'b0, hold);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit         ok;
        bit         em;
        logic [1:0] ea;
        logic [3:0] key;
        int         n;
        int         pulses;
        int         first;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("in reset");
        rst = 1'b0;
        #1;
        chk("ready before first edge", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("ready after reset", 32'(req_ready), 1);

        // 1: fill and hit
        do_write(2'd0, 4'd5, 0);
        do_write(2'd1, 4'd3, 1);
        do_write(2'd2, 4'd12, 2);
        do_write(2'd3, 4'd7, 0);
        chk("cam_din holds", 32'(cam_din), 7);
        chk("cam_waddr holds", 32'(cam_write_addr), 3);
        search_chk(4'd12, 1'b1, 2'd2, 0);
        chk("key held after search", 32'(cam_cmp_din), 12);

        // 2: miss
        search_chk(4'd9, 1'b0, 2'd0, 0);

        // 3: backpressure on response
        search_chk(4'd5, 1'b1, 2'd0, 5);
        repeat (3) @(negedge clk);
        chk("hit counted once", 32'(hit_cnt), 32'(exp_hit));

        // 4: overwrite during busy, then re-search
        do_write(2'd2, 4'd9, 3);
        search_chk(4'd9, 1'b1, 2'd2, 0);
        search_chk(4'd12, 1'b0, 2'd0, 1);

        // 5a: search busy timeout
        send(1'b1, 4'd3, 2'd0, ok);
        force_busy = 1'b1;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n = i;
            if (rsp_valid === 1'b1) break;
        end
        chk("search timeout latency", 32'(n), BusyTimeout + 1);
        get_rsp("timeout", 1'b0, 2'd0, 1'b1, 2);
        force_busy = 1'b0;

        // 5b: write busy timeout
        wr_busy_len = 0;
        send(1'b0, 4'd7, 2'd3, ok);
        if (ok) begin
            ref_mem[3] = 4'd7;
            ref_vld[3] = 1'b1;
        end
        force_busy = 1'b1;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (wr_timeout === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("wr_timeout pulse count", 32'(pulses), 1);
        chk("wr_timeout timing", 32'(first), BusyTimeout + 2);
        force_busy = 1'b0;
        #1;
        chk("idle after wr timeout", 32'(req_ready), 1);

        // 6: reset in the middle of a search
        send(1'b1, 4'd5, 2'd0, ok);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("mid-search reset");
        exp_hit  = 0;
        exp_miss = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) pulses++;
        end
        chk("no response after reset", 32'(pulses), 0);
        chk("ready after reset release", 32'(req_ready), 1);

        // Random mix against the reference table
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(1, 0) == 0) begin
                do_write(2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                         int'($urandom_range(4, 0)));
            end else begin
                key = 4'($urandom_range(15, 0));
                ref_lookup(key, em, ea);
                search_chk(key, em, ea, int'($urandom_range(3, 0)));
            end
        end
        chk("final hit_cnt", 32'(hit_cnt), 32'(exp_hit));
        chk("final miss_cnt", 32'(miss_cnt), 32'(exp_miss));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
